// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle linking the core's fetch and data ports, the arbiter and the
// memory slave. The arbiter takes the slave view; the core and memory side take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_mask;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_mask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, d_mask, mem_rdata, mem_ack,
        output i_valid, i_rdata, d_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, d_mask, mem_rdata, mem_ack,
        input  i_valid, i_rdata, d_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data accesses.
// Build option MEM_ARB_ROUND_ROBIN_EN replaces fixed data priority with round-robin on collisions.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    state_t            r_state;
    grant_t            r_last_grant;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [MASK_W-1:0] r_mem_mask;

    logic w_idle;
    logic w_d_pend;
    logic w_grant_d;
    logic w_grant_i;
    logic w_done;

    // Grant selection in IDLE and completion detection while a request is outstanding.
    always_comb begin
        w_idle   = (r_state == ST_IDLE);
        w_d_pend = bus.d_rd | bus.d_wr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_grant_d = w_idle & w_d_pend & (~bus.i_req | (r_last_grant == GNT_INST));
`else
        w_grant_d = w_idle & w_d_pend;
`endif
        w_grant_i = w_idle & bus.i_req & ~w_grant_d;
        // An ack only counts while mem_req is up, and never in a reset cycle.
        w_done    = ~reset & r_mem_req & bus.mem_ack;
    end

    // Arbitration FSM: latches the granted command and holds mem_req until ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_mask  <= {MASK_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_req <= 1'b0;
                    if (w_grant_d) begin
                        r_state     <= ST_D_BUSY;
                        r_mem_we    <= bus.d_wr;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_mask  <= bus.d_wr ? bus.d_mask : {MASK_W{1'b1}};
                    end else if (w_grant_i) begin
                        r_state    <= ST_I_BUSY;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.i_addr;
                        r_mem_mask <= {MASK_W{1'b1}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Remembers the most recent grant for collision fairness.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GNT_INST;
        end else if (w_grant_d) begin
            r_last_grant <= GNT_DATA;
        end else if (w_grant_i) begin
            r_last_grant <= GNT_INST;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_mask  = r_mem_mask;

    assign bus.i_valid = w_done & (r_state == ST_I_BUSY);
    assign bus.d_valid = w_done & (r_state == ST_D_BUSY);
    assign bus.i_rdata = bus.i_valid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.d_rdata = bus.d_valid ? bus.mem_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-port expected queues, a behavioural
// memory with programmable ack latency, and latency/command checks per transaction.
module tb_mem_port_arbiter;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } txn_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   lat;
    bit   stray;
    bit   mon_en;
    txn_t iq[$];
    txn_t dq[$];
    logic [31:0] mem_m [logic [31:0]];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: acks after lat extra cycles of mem_req, applies masked writes.
    initial begin
        int run;
        logic [31:0] w;
        run = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req === 1'b1) begin
                run++;
                if (run == lat + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rd_word(bus.mem_addr);
                    if (bus.mem_we === 1'b1) begin
                        w = rd_word(bus.mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_mask[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        mem_m[bus.mem_addr] = w;
                    end
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                run = 0;
                bus.mem_ack   = stray;
                bus.mem_rdata = stray ? 32'hBAD0_BAD0 : 32'h0;
            end
        end
    end

    // Monitor: pops the scoreboard on each valid and checks command and returned data.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_eq("both_valid", {31'b0, bus.i_valid & bus.d_valid}, 32'd0);
                if (bus.i_valid === 1'b1) begin
                    if (iq.size() == 0) begin
                        check_eq("i_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = iq.pop_front();
                        check_eq("i_mem_addr", bus.mem_addr, e.addr);
                        check_eq("i_mem_we", {31'b0, bus.mem_we}, 32'd0);
                        check_eq("i_mem_mask", {28'b0, bus.mem_mask}, 32'hF);
                        check_eq("i_rdata", bus.i_rdata, e.rdata);
                    end
                end else begin
                    check_eq("i_rdata_idle", bus.i_rdata, 32'h0);
                end
                if (bus.d_valid === 1'b1) begin
                    if (dq.size() == 0) begin
                        check_eq("d_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = dq.pop_front();
                        check_eq("d_mem_addr", bus.mem_addr, e.addr);
                        check_eq("d_mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                        check_eq("d_mem_mask", {28'b0, bus.mem_mask}, {28'b0, e.mask});
                        if (e.we) check_eq("d_mem_wdata", bus.mem_wdata, e.wdata);
                        check_eq("d_rdata", bus.d_rdata, e.rdata);
                    end
                end else begin
                    check_eq("d_rdata_idle", bus.d_rdata, 32'h0);
                end
            end
        end
    end

    task automatic drive_fetch(input logic [31:0] a, output int vc);
        txn_t e;
        int t0;
        @(posedge clk);
        #1;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        e.we = 1'b0; e.addr = a; e.wdata = 32'h0; e.mask = 4'hF; e.rdata = rd_word(a);
        iq.push_back(e);
        t0 = cyc;
        vc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.i_valid === 1'b1) begin
                vc = cyc - t0;
                break;
            end
        end
        if (vc < 0) check_eq("i_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
    endtask

    task automatic drive_data(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] m,
                              input bit wiggle, input logic [31:0] alt_a, output int vc);
        txn_t e;
        int t0;
        @(posedge clk);
        #1;
        bus.d_rd = rd; bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = wd; bus.d_mask = m;
        e.we = wr; e.addr = a; e.wdata = wd; e.mask = wr ? m : 4'hF; e.rdata = rd_word(a);
        dq.push_back(e);
        t0 = cyc;
        vc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.d_valid === 1'b1) begin
                vc = cyc - t0;
                break;
            end
            if (wiggle && k >= 1) begin
                bus.d_addr  = alt_a;
                bus.d_wdata = ~wd;
            end
        end
        if (vc < 0) check_eq("d_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
    endtask

    initial begin
        int vi, vd, l;
        logic [31:0] a;
        n_checks = 0; n_errors = 0; lat = 0; stray = 1'b0; mon_en = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_mask = 4'h0;
        mem_m[32'h100] = 32'h0050_0093;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check_eq("rst_mem_mask", {28'b0, bus.mem_mask}, 32'h0);
        check_eq("rst_valids", {30'b0, bus.i_valid, bus.d_valid}, 32'd0);
        mon_en = 1'b1;

        lat = 1;
        drive_fetch(32'h100, vi);
        check_eq("fetch_lat", vi, 32'd3);

        lat = 0;
        drive_data(1'b0, 1'b1, 32'h2004, 32'hAABB_CCDD, 4'b0100, 1'b0, 32'h0, vd);
        check_eq("store_lat", vd, 32'd2);
        drive_data(1'b1, 1'b0, 32'h2004, 32'h0, 4'h0, 1'b0, 32'h0, vd);
        check_eq("load_lat", vd, 32'd2);

        fork
            drive_fetch(32'h200, vi);
            drive_data(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 32'h0, vd);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check_eq("coll_i_lat", vi, 32'd2);
        check_eq("coll_d_lat", vd, 32'd5);
`else
        check_eq("coll_d_lat", vd, 32'd2);
        check_eq("coll_i_lat", vi, 32'd5);
`endif

        lat = 4;
        drive_data(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h80, vd);
        check_eq("stable_lat", vd, 32'd6);

        lat = 2;
        drive_data(1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'b1001, 1'b0, 32'h0, vd);
        check_eq("rdwr_lat", vd, 32'd4);

        lat = 0;
        @(posedge clk);
        #1;
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1; bus.i_req = 1'b0;
        @(negedge clk);
        check_eq("rst_ack_req", {31'b0, bus.mem_req & bus.mem_ack}, 32'd1);
        check_eq("rst_no_ivalid", {31'b0, bus.i_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check_eq("rst_mid_mem_addr", bus.mem_addr, 32'h0);
        drive_fetch(32'h104, vi);
        check_eq("post_rst_lat", vi, 32'd2);

        @(posedge clk);
        #1;
        stray = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stray_no_valid", {30'b0, bus.i_valid, bus.d_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        stray = 1'b0;

        for (int n = 0; n < 10; n++) begin
            l = $urandom_range(0, 3);
            lat = l;
            a = {20'h0, $urandom_range(0, 255), 2'b00};
            if ((n % 3) == 0) begin
                drive_fetch(a, vi);
                check_eq("rand_i_lat", vi, 2 + l);
            end else begin
                drive_data(n[0], ~n[0], a, $urandom, $urandom_range(1, 15), 1'b0, 32'h0, vd);
                check_eq("rand_d_lat", vd, 2 + l);
            end
        end

        repeat (3) @(posedge clk);
        check_eq("iq_drained", iq.size(), 32'd0);
        check_eq("dq_drained", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch port and data port, for unified-memory SoC builds.
- Sits between the 5-stage rv32i core and the memory/bus slave.
- Latches one requester's command, drives it to memory until acknowledged, then returns the result to that requester only.
- Fixed data-over-instruction priority by default; round-robin as a build option.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width; mask width is DATA_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request, level, held until i_valid
- i_addr  in  ADDR_W  fetch address
- i_valid  out  1  fetch complete pulse
- i_rdata  out  DATA_W  fetched word, meaningful when i_valid
- d_rd  in  1  data read request, level, held until d_valid
- d_wr  in  1  data write request, level, held until d_valid
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data, already lane-aligned
- d_mask  in  DATA_W/8  byte-write mask
- d_valid  out  1  data access complete pulse (reads and writes)
- d_rdata  out  DATA_W  raw memory word, meaningful when d_valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_mask  out  DATA_W/8  memory byte mask
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion from memory

Behaviour:
- Clocking and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_mask=0, i_valid=0, d_valid=0, last_grant=INST.
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE with a data request pending (d_rd|d_wr) -> D_BUSY. Latch mem_addr=d_addr, mem_we=d_wr, mem_wdata=d_wdata, mem_mask=d_mask (mask forced to all-ones for reads).
- IDLE with only i_req pending -> I_BUSY. Latch mem_addr=i_addr, mem_we=0, mem_mask=all-ones.
- IDLE with both pending: D wins (default priority).
- mem_req=1 in both BUSY states and is registered, so it asserts the cycle after the grant. The command is stable for the whole BUSY period; requester inputs may change without effect.
- I_BUSY & mem_ack: i_valid=1 combinationally in that cycle, i_rdata=mem_rdata pass-through; next state IDLE.
- D_BUSY & mem_ack: d_valid=1 in that cycle, d_rdata=mem_rdata; next state IDLE.
- mem_ack outside BUSY is ignored and produces no valid.
- Every transaction returns to IDLE for one cycle, so back-to-back transactions cost one bubble. Minimum latency from request to valid is 2 cycles with a zero-wait memory (ack in the first mem_req cycle).
- A requester still asserting its request in the IDLE cycle after its valid starts a new transaction (re-fetch semantics).
- d_rd and d_wr both high: treated as a write; d_rd ignored.
- i_valid and d_valid are never high in the same cycle.
- i_rdata/d_rdata present mem_rdata only when the matching valid is high; otherwise 0.
- Reset mid-transaction: aborts. mem_req drops on the next edge, no valid is issued, and an ack arriving in the reset cycle is discarded.
- last_grant updates on each grant; it is used only under the optional feature.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined: if both requesters are pending in IDLE, grant the one opposite to last_grant. A single pending requester is granted regardless.
- When undefined: fixed data priority; instruction fetch may wait indefinitely while data requests persist. last_grant is still maintained but unused.

Test Plan:
- Fetch alone: i_req=1, i_addr=0x100, memory acks 1 cycle after mem_req rises with rdata=0x00500093 -> mem_req high 2 cycles with mem_addr=0x100, mem_we=0; i_valid pulse with i_rdata=0x00500093 at cycle 3; d_valid stays 0.
- Store: d_wr=1, d_addr=0x2004, d_wdata=0xAABBCCDD, d_mask=4'b0100, zero-wait ack -> mem_we=1, mem_mask=4'b0100, mem_wdata=0xAABBCCDD; d_valid pulse at cycle 2.
- Collision: i_req and d_rd both rise at cycle 0, ack latency 0 -> data granted first, d_valid at cycle 2, IDLE at cycle 3, i_valid at cycle 5. With MEM_ARB_ROUND_ROBIN_EN and last_grant=DATA, the fetch is served first instead.
- Stable command: change d_addr from 0x40 to 0x80 while in D_BUSY with a 4-cycle ack latency -> mem_addr stays 0x40 until ack.
- Reset mid-operation: assert reset in the second cycle of I_BUSY while mem_ack=1 -> no i_valid; mem_req=0 and state IDLE after the edge.
- Illegal combination: d_rd=1 and d_wr=1 -> mem_we=1 and the write completes with d_valid.
